// File: rtl/pixel_align_mux.sv
// Video-path alignment and source select. Delays the raster timing bundle by MAX_DELAY+1,
// re-times each pixel source onto it, and switches sources/delays only on frame boundaries.
module pixel_align_mux #(
   parameter int NUM_SRC   = 2,
   parameter int DATA_W    = 24,
   parameter int SYNC_W    = 3,
   parameter int AD_BIT    = 2,
   parameter int MAX_DELAY = 64,
   parameter int DELAY_W   = $clog2(MAX_DELAY + 1),
   parameter int SEL_W     = $clog2(NUM_SRC)
) (
   input  logic                       clk_in,
   input  logic                       rst_in_n,
   input  logic [SYNC_W-1:0]          sync_in,
   input  logic                       frame_start_in,
   input  logic [NUM_SRC*DATA_W-1:0]  src_data_in,
   input  logic [NUM_SRC*DELAY_W-1:0] src_delay_in,
   input  logic [SEL_W-1:0]           sel_in,
   output logic [DATA_W-1:0]          data_out,
   output logic [SYNC_W-1:0]          sync_out,
   output logic                       frame_out,
   output logic [SEL_W-1:0]           sel_active_out,
   output logic [NUM_SRC-1:0]         err_out
);

   localparam int                 L         = MAX_DELAY + 1;
   localparam int                 CNT_W     = $clog2(L);
   localparam logic [DELAY_W-1:0] MAX_D     = DELAY_W'(MAX_DELAY);
   localparam logic [SEL_W:0]     NUM_SRC_X = (SEL_W + 1)'(NUM_SRC);
   localparam logic [CNT_W-1:0]   FILL_LAST = CNT_W'(L - 1);

   // Delay-line storage carries no reset; the fill counter masks its contents instead.
   logic [SYNC_W:0]      t_line [MAX_DELAY];
   logic [DATA_W-1:0]    s_line [NUM_SRC][1:MAX_DELAY];

   logic [CNT_W-1:0]     fill_cnt;
   logic [DELAY_W-1:0]   d_q    [NUM_SRC];
   logic [DELAY_W-1:0]   d_next [NUM_SRC];
   logic [SEL_W-1:0]     sel_next;
   logic [NUM_SRC-1:0]   err_next;
   logic [SYNC_W:0]      t_tail;
   logic                 filled;
   logic                 boundary;
   logic [DELAY_W-1:0]   tap;
   logic [DATA_W-1:0]    pix;

   always_ff @(posedge clk_in) begin
      t_line[0] <= {frame_start_in, sync_in};
      for (int i = 1; i < MAX_DELAY; i++) t_line[i] <= t_line[i-1];
      for (int k = 0; k < NUM_SRC; k++) begin
         s_line[k][1] <= src_data_in[k*DATA_W +: DATA_W];
         for (int i = 2; i <= MAX_DELAY; i++) s_line[k][i] <= s_line[k][i-1];
      end
   end

   assign t_tail   = t_line[MAX_DELAY-1];
   assign filled   = (fill_cnt == FILL_LAST);
   assign boundary = filled & t_tail[SYNC_W];

   // Shadow update: the boundary edge itself already uses the new delays and selection.
   always_comb begin
      d_next   = d_q;
      err_next = err_out;
      sel_next = sel_active_out;
      if (boundary) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            if (src_delay_in[k*DELAY_W +: DELAY_W] > MAX_D) begin
               d_next[k]   = MAX_D;
               err_next[k] = 1'b1;
            end else begin
               d_next[k]   = src_delay_in[k*DELAY_W +: DELAY_W];
            end
         end
         if ({1'b0, sel_in} < NUM_SRC_X) sel_next = sel_in;
      end
   end

   // Only the selected source's line is tapped; tap 0 is the live input.
   always_comb begin
      tap = MAX_D - d_next[sel_next];
      pix = src_data_in[sel_next*DATA_W +: DATA_W];
      for (int i = 1; i <= MAX_DELAY; i++) begin
         if (tap == DELAY_W'(i)) pix = s_line[sel_next][i];
      end
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         fill_cnt       <= '0;
         sync_out       <= '0;
         frame_out      <= 1'b0;
         data_out       <= '0;
         sel_active_out <= '0;
         err_out        <= '0;
         for (int k = 0; k < NUM_SRC; k++) d_q[k] <= MAX_D;
      end else begin
         if (!filled) fill_cnt <= fill_cnt + 1'b1;
         sync_out       <= filled ? t_tail[SYNC_W-1:0] : '0;
         frame_out      <= boundary;
         data_out       <= (filled && t_tail[AD_BIT]) ? pix : '0;
         sel_active_out <= sel_next;
         err_out        <= err_next;
         d_q            <= d_next;
      end
   end

endmodule
